fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 32, maximum WAIT cycles before abandoning an operation (legal range 2..255).
REQ-002 Port: clock_100Khz  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid / req1_valid  in  1 each  requester N has an operation pending.
REQ-005 Port: req0_op_a, req0_op_b / req1_op_a, req1_op_b  in  32 each  operands of requester N.
REQ-006 Port: req0_ready / req1_ready  out  1 each  operation of requester N accepted this cycle.
REQ-007 Port: rsp0_valid / rsp1_valid  out  1 each  one-cycle response strobe for requester N.
REQ-008 Port: rsp_data  out  32  result of the last completed operation.
REQ-009 Port: rsp_status  out  4  status code: OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3.
REQ-010 Port: rsp_timeout  out  1  last response was produced by timeout.
REQ-011 Port: fpu_start  out  1  one-cycle launch pulse to the shared FPU.
REQ-012 Port: fpu_op_a, fpu_op_b  out  32 each  operands presented to the FPU.
REQ-013 Port: fpu_done  in  1  FPU result valid this cycle.
REQ-014 Port: fpu_result  in  32  FPU result; fpu_status  in  4  FPU status code.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESPOND; only one operation in flight at any time.
REQ-016 IDLE: no valid -> stay; any valid -> grant one requester, latch its operands and the grant index, go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; single valid -> grant it.
REQ-018 reqN_ready SHALL be combinational, high only in IDLE for the granted requester, and never high for both.
REQ-019 ISSUE: fpu_start=1 for exactly one cycle with the latched operands, clear wait counter, go to WAIT.
REQ-020 fpu_op_a/fpu_op_b SHALL hold the latched operands stable from ISSUE until leaving WAIT.
REQ-021 WAIT: fpu_done=1 -> capture fpu_result/fpu_status, set timeout flag 0, go to RESPOND; else increment counter.
REQ-022 WAIT: counter == TIMEOUT_CYCLES-1 without fpu_done -> capture data 32'h0, status INEXACT(3), timeout flag 1, go to RESPOND.
REQ-023 fpu_done SHALL be ignored in IDLE, ISSUE and RESPOND.
REQ-024 RESPOND: rspN_valid=1 for one cycle for the granted requester only; rsp_data, rsp_status, rsp_timeout update at entry to RESPOND and hold until the next RESPOND; go to IDLE.
REQ-025 Latency: accept at edge T -> fpu_start during cycle T+1 -> done seen at cycle D -> rspN_valid during cycle D+1; minimum 4 cycles accept-to-accept.
REQ-026 Requester dropping valid while not ready SHALL be legal; no operation recorded for it.
REQ-027 Counter SHALL be 8 bits and SHALL not wrap inside WAIT.

Reset
REQ-028 reset=0 SHALL immediately force IDLE; last-grant = requester 1 (requester 0 wins the first contention).
REQ-029 Reset values: all ready/valid strobes 0, fpu_start 0, fpu_op_a/b 0, rsp_data 0, rsp_status EXACT(2), rsp_timeout 0, counter 0.
REQ-030 Reset mid-operation SHALL drop the in-flight operation with no response; a late fpu_done after release SHALL be ignored.

Verification
REQ-031 Single request: req0 valid, A=32'h3F800000, B=32'h40000000; FPU done 6 cycles after start with 32'h40400000, status 2 -> req0_ready one cycle, one fpu_start, rsp0_valid one cycle, rsp_data 32'h40400000, rsp_status 2, rsp_timeout 0.
REQ-032 Contention: both valid continuously from reset -> grant order 0,1,0,1; ready never simultaneous; each rspN_valid matches its grant.
REQ-033 Timeout: req1 valid, fpu_done held 0 -> rsp1_valid exactly TIMEOUT_CYCLES+1 cycles after fpu_start, rsp_data 0, rsp_status 3, rsp_timeout 1.
REQ-034 Stray done: fpu_done pulsed in IDLE and ISSUE -> no state change, no response; real done later completes normally.
REQ-035 Reset in WAIT: assert reset 3 cycles after fpu_start -> outputs at reset values immediately; no rsp strobe; after release req0 wins a contended grant.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// -----------------------------------------------------------------------------
// fpu_arbiter_if
// Bundles every handshake and data signal between the two requesters, the
// shared FPU and the fpu_arbiter. Clock and reset stay plain module ports.
//
//   Requester side : reqN_valid, reqN_op_a, reqN_op_b  -> arbiter
//                    reqN_ready, rspN_valid,
//                    rsp_data, rsp_status, rsp_timeout <- arbiter
//   FPU side       : fpu_start, fpu_op_a, fpu_op_b     <- arbiter
//                    fpu_done, fpu_result, fpu_status  -> arbiter
//
// Modports:
//   master : the environment (requesters + FPU) that talks to the arbiter
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface fpu_arbiter_if;

   // requester 0 / 1 request channel
   logic        req0_valid;
   logic [31:0] req0_op_a;
   logic [31:0] req0_op_b;
   logic        req0_ready;
   logic        req1_valid;
   logic [31:0] req1_op_a;
   logic [31:0] req1_op_b;
   logic        req1_ready;

   // shared response channel
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_status;
   logic        rsp_timeout;

   // shared FPU channel
   logic        fpu_start;
   logic [31:0] fpu_op_a;
   logic [31:0] fpu_op_b;
   logic        fpu_done;
   logic [31:0] fpu_result;
   logic [3:0]  fpu_status;

   modport master (
      output req0_valid, req0_op_a, req0_op_b,
      output req1_valid, req1_op_a, req1_op_b,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data, rsp_status, rsp_timeout,
      input  fpu_start, fpu_op_a, fpu_op_b,
      output fpu_done, fpu_result, fpu_status
   );

   modport slave (
      input  req0_valid, req0_op_a, req0_op_b,
      input  req1_valid, req1_op_a, req1_op_b,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_data, rsp_status, rsp_timeout,
      output fpu_start, fpu_op_a, fpu_op_b,
      input  fpu_done, fpu_result, fpu_status
   );

endinterface

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Shares one FPU between two requesters. One operation is in flight at a
// time; contention is resolved round-robin. An operation whose FPU result
// does not arrive within TIMEOUT_CYCLES wait cycles is abandoned and answered
// with data 0, status INEXACT and the timeout flag set.
//
// Parameters:
//   TIMEOUT_CYCLES : wait cycles before abandoning an operation (2..255)
//
// Ports:
//   clock_100Khz : single clock, rising edge
//   reset        : asynchronous, active-low
//   bus          : fpu_arbiter_if.slave (requesters, response, FPU)
//
// Flow: IDLE (grant + latch) -> ISSUE (fpu_start) -> WAIT (done / timeout)
//       -> RESPOND (rspN_valid) -> IDLE
// -----------------------------------------------------------------------------
module fpu_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic         clock_100Khz,
   input  logic         reset,
   fpu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESPOND
   } state_e;

   localparam logic [3:0] STATUS_EXACT   = 4'd2;
   localparam logic [3:0] STATUS_INEXACT = 4'd3;
   localparam logic [7:0] CNT_LAST       = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q,       state_d;
   logic        grant_q,       grant_d;       // requester of the current/last operation
   logic [31:0] op_a_q,        op_a_d;
   logic [31:0] op_b_q,        op_b_d;
   logic [7:0]  cnt_q,         cnt_d;
   logic [31:0] rsp_data_q,    rsp_data_d;
   logic [3:0]  rsp_status_q,  rsp_status_d;
   logic        rsp_timeout_q, rsp_timeout_d;

   logic any_valid;
   logic pick;

   assign any_valid = bus.req0_valid | bus.req1_valid;

   // Under contention hand the grant to the requester that did not get the
   // previous one; otherwise serve whichever requester is asking.
   assign pick = (bus.req0_valid & bus.req1_valid) ? ~grant_q : bus.req1_valid;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         grant_q       <= 1'b1;       // requester 0 wins the first contention
         op_a_q        <= '0;
         op_b_q        <= '0;
         cnt_q         <= '0;
         rsp_data_q    <= '0;
         rsp_status_q  <= STATUS_EXACT;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         cnt_q         <= cnt_d;
         rsp_data_q    <= rsp_data_d;
         rsp_status_q  <= rsp_status_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a hold default before the case so no path
      // leaves it unassigned and no latch is inferred.
      state_d       = state_q;
      grant_d       = grant_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      cnt_d         = cnt_q;
      rsp_data_d    = rsp_data_q;
      rsp_status_d  = rsp_status_q;
      rsp_timeout_d = rsp_timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               grant_d = pick;
               op_a_d  = pick ? bus.req1_op_a : bus.req0_op_a;
               op_b_d  = pick ? bus.req1_op_b : bus.req0_op_b;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // A result arriving on the last permitted cycle still wins over
            // the timeout.
            if (bus.fpu_done) begin
               rsp_data_d    = bus.fpu_result;
               rsp_status_d  = bus.fpu_status;
               rsp_timeout_d = 1'b0;
               state_d       = ST_RESPOND;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d    = '0;
               rsp_status_d  = STATUS_INEXACT;
               rsp_timeout_d = 1'b1;
               state_d       = ST_RESPOND;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_RESPOND: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.fpu_start  = 1'b0;
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Gated by reset so nothing looks accepted while the FSM is held.
            if (reset && any_valid) begin
               bus.req0_ready = ~pick;
               bus.req1_ready = pick;
            end
         end
         ST_ISSUE: begin
            bus.fpu_start = 1'b1;
         end
         ST_RESPOND: begin
            bus.rsp0_valid = ~grant_q;
            bus.rsp1_valid = grant_q;
         end
         default: begin
         end
      endcase
   end

   assign bus.fpu_op_a    = op_a_q;
   assign bus.fpu_op_b    = op_b_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_status  = rsp_status_q;
   assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
// Requester and FPU models drive the arbiter; every operation the FPU model
// sees launched pushes its expected response (requester, data, status,
// timeout flag, arrival cycle) onto a scoreboard queue. An independent
// monitor tracks the arbiter abstractly (busy / last winner) to check grants,
// launches and operand stability, and pops the queue on every response.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;

   localparam int T = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpu_arbiter_if bus ();

   fpu_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clock_100Khz (clk),
      .reset        (rst_n),
      .bus          (bus)
   );

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic [3:0]  st;
      bit          to;
      int unsigned due;
   } rsp_t;

   rsp_t exp_q[$];
   int   grant_log[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // configuration, written by main only
   int          gen_mode       = 0;   // 0 manual, 1 random, 2 always valid
   bit          drop_en        = 0;
   bit          stray_en       = 0;
   bit          stray_issue_en = 0;
   int          fpu_mode       = 0;   // 0 fixed, 1 random, 2 never done
   int          fix_lat        = 6;
   logic [31:0] fix_res        = '0;
   logic [3:0]  fix_st         = 4'd2;
   int          load_cnt[2]    = '{0, 0};
   logic [31:0] load_a[2];
   logic [31:0] load_b[2];

   // driver state
   bit          want[2]      = '{0, 0};
   bit          auto_w[2]    = '{0, 0};
   int          load_seen[2] = '{0, 0};
   logic [31:0] cur_a[2];
   logic [31:0] cur_b[2];
   int          cur_idx    = 0;
   int          rem        = 0;
   bit          in_wait    = 0;
   bit          stray_next = 0;
   logic [31:0] pend_res;
   logic [3:0]  pend_st;

   // monitor state
   bit          m_busy = 0;
   int          m_last = 1;
   int unsigned acc_cyc = 0;
   logic [31:0] acc_a, acc_b;
   logic [31:0] h_data = '0;
   logic [3:0]  h_st   = 4'd2;
   bit          h_to   = 0;
   int          rsp_cnt   = 0;
   int          start_cnt = 0;
   int          rdy_cnt[2] = '{0, 0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver: requesters and FPU
   // ---------------------------------------------------------------------------
   task automatic plan_fpu();
      int lat;
      int r;
      in_wait = 1;
      case (fpu_mode)
         0: lat = fix_lat;
         1: begin
            r = $urandom_range(0, 9);
            if (r < 5)       lat = $urandom_range(1, 5);
            else if (r == 5) lat = T;          // done on the last permitted cycle
            else if (r == 6) lat = T - 1;
            else if (r == 7) lat = T + 1;      // never answered
            else             lat = $urandom_range(6, 12);
         end
         default: lat = T + 1;
      endcase
      if (lat > T) begin
         exp_q.push_back('{idx: cur_idx, data: 32'h0, st: 4'd3, to: 1'b1, due: cyc + T + 1});
      end else begin
         rem      = lat;
         pend_res = (fpu_mode == 0) ? fix_res : $urandom;
         pend_st  = (fpu_mode == 0) ? fix_st : 4'($urandom_range(0, 3));
         exp_q.push_back('{idx: cur_idx, data: pend_res, st: pend_st, to: 1'b0, due: cyc + lat + 1});
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 2; i++) begin
         if (load_seen[i] != load_cnt[i]) begin
            load_seen[i] = load_cnt[i];
            want[i]      = 1;
            auto_w[i]    = 0;
            cur_a[i]     = load_a[i];
            cur_b[i]     = load_b[i];
         end else if (!want[i]) begin
            if (gen_mode == 2 || (gen_mode == 1 && $urandom_range(0, 3) == 0)) begin
               want[i]   = 1;
               auto_w[i] = 1;
               cur_a[i]  = $urandom;
               cur_b[i]  = $urandom;
            end
         end else if (auto_w[i] && (gen_mode == 0 || (drop_en && $urandom_range(0, 7) == 0))) begin
            want[i] = 0;
         end
      end
      bus.req0_valid = want[0];
      bus.req0_op_a  = cur_a[0];
      bus.req0_op_b  = cur_b[0];
      bus.req1_valid = want[1];
      bus.req1_op_a  = cur_a[1];
      bus.req1_op_b  = cur_b[1];

      bus.fpu_done = 1'b0;
      if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            bus.fpu_done   = 1'b1;
            bus.fpu_result = pend_res;
            bus.fpu_status = pend_st;
         end
      end else if (stray_next || (stray_en && !in_wait && $urandom_range(0, 2) == 0)) begin
         bus.fpu_done   = 1'b1;
         bus.fpu_result = $urandom;
         bus.fpu_status = 4'($urandom_range(0, 15));
      end
      stray_next = 0;
   endtask

   initial begin : driver
      for (int i = 0; i < 2; i++) begin
         cur_a[i] = '0;
         cur_b[i] = '0;
      end
      bus.req0_valid = 1'b0;  bus.req0_op_a = '0;  bus.req0_op_b = '0;
      bus.req1_valid = 1'b0;  bus.req1_op_a = '0;  bus.req1_op_b = '0;
      bus.fpu_done   = 1'b0;  bus.fpu_result = '0; bus.fpu_status = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
               want[i]   = 0;
               auto_w[i] = 0;
            end
            in_wait    = 0;
            stray_next = 0;
         end else begin
            if (bus.req0_ready) begin want[0] = 0; cur_idx = 0; stray_next = stray_issue_en; end
            if (bus.req1_ready) begin want[1] = 0; cur_idx = 1; stray_next = stray_issue_en; end
            if (bus.rsp0_valid || bus.rsp1_valid) in_wait = 0;
            if (bus.fpu_start) plan_fpu();
         end
         @(posedge clk);
         #1;
         drive_inputs();
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   task automatic monitor_cycle();
      logic [1:0] rdy;
      logic [1:0] exp_rdy;
      logic [1:0] rsp;
      int         g;
      rsp_t       e;

      rdy = {bus.req1_ready, bus.req0_ready};
      rsp = {bus.rsp1_valid, bus.rsp0_valid};
      if (rdy[0]) begin rdy_cnt[0]++; grant_log.push_back(0); end
      if (rdy[1]) begin rdy_cnt[1]++; grant_log.push_back(1); end

      // arbitration: an idle arbiter must accept someone, a busy one no one
      exp_rdy = 2'b00;
      if (!m_busy && (bus.req0_valid || bus.req1_valid)) begin
         if (bus.req0_valid && bus.req1_valid) g = 1 - m_last;
         else                                  g = bus.req1_valid ? 1 : 0;
         exp_rdy = (g == 1) ? 2'b10 : 2'b01;
         m_last  = g;
         m_busy  = 1;
         acc_cyc = cyc;
         acc_a   = (g == 1) ? bus.req1_op_a : bus.req0_op_a;
         acc_b   = (g == 1) ? bus.req1_op_b : bus.req0_op_b;
      end
      check("ready", rdy, exp_rdy);

      // launch exactly one cycle after acceptance, operands held until response
      if (bus.fpu_start) start_cnt++;
      check("fpu_start", bus.fpu_start, m_busy && (cyc == acc_cyc + 1));
      if (m_busy && cyc > acc_cyc && rsp == 2'b00) begin
         check("fpu_op_a", bus.fpu_op_a, acc_a);
         check("fpu_op_b", bus.fpu_op_b, acc_b);
      end

      if (rsp != 2'b00) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", rsp, 2'b00);
         end else begin
            e = exp_q.pop_front();
            check("rsp_idx",     rsp, (e.idx == 1) ? 2'b10 : 2'b01);
            check("rsp_data",    bus.rsp_data, e.data);
            check("rsp_status",  bus.rsp_status, e.st);
            check("rsp_timeout", bus.rsp_timeout, e.to);
            check("rsp_cycle",   cyc, e.due);
            h_data = e.data;
            h_st   = e.st;
            h_to   = e.to;
         end
         m_busy = 0;
         rsp_cnt++;
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
         e = exp_q.pop_front();
         check("rsp_missing", rsp, (e.idx == 1) ? 2'b10 : 2'b01);
         m_busy = 0;
         rsp_cnt++;
      end

      check("rsp_data_hold",    bus.rsp_data, h_data);
      check("rsp_status_hold",  bus.rsp_status, h_st);
      check("rsp_timeout_hold", bus.rsp_timeout, h_to);
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            grant_log.delete();
            m_busy = 0;
            m_last = 1;
            h_data = '0;
            h_st   = 4'd2;
            h_to   = 0;
         end else begin
            monitor_cycle();
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   task automatic wait_rsp(input int n, input int budget);
      int target;
      int k;
      target = rsp_cnt + n;
      k      = 0;
      while (rsp_cnt < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      check("wait_rsp_budget", rsp_cnt >= target, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((m_busy || exp_q.size() > 0) && k < budget) begin
         @(posedge clk);
         k++;
      end
      check("wait_idle_budget", m_busy || exp_q.size() > 0, 1'b0);
      repeat (2) @(posedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req0_ready"},  bus.req0_ready, 1'b0);
      check({tag, "_req1_ready"},  bus.req1_ready, 1'b0);
      check({tag, "_rsp0_valid"},  bus.rsp0_valid, 1'b0);
      check({tag, "_rsp1_valid"},  bus.rsp1_valid, 1'b0);
      check({tag, "_fpu_start"},   bus.fpu_start, 1'b0);
      check({tag, "_fpu_op_a"},    bus.fpu_op_a, 32'h0);
      check({tag, "_fpu_op_b"},    bus.fpu_op_b, 32'h0);
      check({tag, "_rsp_data"},    bus.rsp_data, 32'h0);
      check({tag, "_rsp_status"},  bus.rsp_status, 4'd2);
      check({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
   endtask

   initial begin : main
      int r0, s0, k;

      // reset state
      repeat (3) @(posedge clk);
      #2;
      check_reset_values("rst");
      @(posedge clk);
      #3 rst_n = 1'b1;

      // stray done pulses while idle must not produce anything
      stray_en = 1;
      repeat (12) @(posedge clk);
      stray_en = 0;

      // single request with a stray done during ISSUE
      stray_issue_en = 1;
      fpu_mode       = 0;
      fix_lat        = 6;
      fix_res        = 32'h4040_0000;
      fix_st         = 4'd2;
      r0             = rdy_cnt[0];
      s0             = start_cnt;
      load_a[0]      = 32'h3F80_0000;
      load_b[0]      = 32'h4000_0000;
      load_cnt[0]++;
      wait_rsp(1, 40);
      repeat (2) @(posedge clk);
      check("single_ready_cycles", rdy_cnt[0] - r0, 1);
      check("single_starts",       start_cnt - s0, 1);
      check("single_rsp_data",     bus.rsp_data, 32'h4040_0000);
      check("single_rsp_status",   bus.rsp_status, 4'd2);
      check("single_rsp_timeout",  bus.rsp_timeout, 1'b0);
      stray_issue_en = 0;

      // contention from reset: grants alternate starting with requester 0
      @(posedge clk);
      #3 rst_n = 1'b0;
      gen_mode = 2;
      fpu_mode = 1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      wait_rsp(4, 4 * (T + 8));
      if (grant_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) check("rr_order", grant_log[i], i % 2);
      end else begin
         check("rr_log_len", grant_log.size(), 4);
      end
      gen_mode = 0;
      wait_idle(3 * T);

      // timeout on requester 1
      fpu_mode  = 2;
      load_a[1] = $urandom;
      load_b[1] = $urandom;
      load_cnt[1]++;
      wait_rsp(1, T + 20);
      #1;
      check("to_rsp_data",    bus.rsp_data, 32'h0);
      check("to_rsp_status",  bus.rsp_status, 4'd3);
      check("to_rsp_timeout", bus.rsp_timeout, 1'b1);
      wait_idle(3 * T);

      // random traffic: drops, stray dones, mixed latencies and timeouts
      gen_mode       = 1;
      drop_en        = 1;
      stray_en       = 1;
      stray_issue_en = 1;
      fpu_mode       = 1;
      wait_rsp(100, 100 * (T + 10));
      gen_mode       = 0;
      drop_en        = 0;
      stray_en       = 0;
      stray_issue_en = 0;
      wait_idle(3 * T);

      // reset three cycles after launch; the late done must be ignored
      fpu_mode  = 0;
      fix_lat   = 6;
      fix_res   = 32'h1234_5678;
      fix_st    = 4'd0;
      s0        = start_cnt;
      load_a[0] = 32'hDEAD_BEEF;
      load_b[0] = 32'hCAFE_F00D;
      load_cnt[0]++;
      k = 0;
      while (start_cnt == s0 && k < 50) begin
         @(posedge clk);
         k++;
      end
      check("rw_start_seen", start_cnt != s0, 1'b1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_reset_values("rw");
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      load_a[0] = $urandom;  load_b[0] = $urandom;
      load_a[1] = $urandom;  load_b[1] = $urandom;
      fix_res   = 32'h0BAD_F00D;
      load_cnt[0]++;
      load_cnt[1]++;
      wait_rsp(2, 2 * (T + 8));
      if (grant_log.size() >= 1) check("rw_first_grant", grant_log[0], 0);
      else                       check("rw_log_len", grant_log.size(), 1);
      wait_idle(3 * T);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
      $fatal(1);
   end

endmodule
